// File: rtl/dual_port_byte_memory.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_byte_memory
// Description : 1W/1R byte-enabled RAM with registered read, optional output
//               register and a self-starting clear engine.
//               Optional feature macro: READ_BYPASS_EN (write-first collisions).
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_byte_memory #(
   parameter int AWIDTH  = 5,
   parameter int DWIDTH  = 32,
   parameter int OUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  wr_en,
   input  logic [AWIDTH-1:0]     wr_addr,
   input  logic [DWIDTH-1:0]     wr_data,
   input  logic [DWIDTH/8-1:0]   wr_be,
   input  logic                  rd_en,
   input  logic [AWIDTH-1:0]     rd_addr,
   output logic [DWIDTH-1:0]     rd_data,
   output logic                  rd_valid
);

   localparam int DEPTH  = 2**AWIDTH;
   localparam int NBYTES = DWIDTH/8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q;
   logic [AWIDTH-1:0]   ptr_q;
   logic                busy_q;
   logic [DWIDTH-1:0]   mem_q [DEPTH];
   logic [DWIDTH-1:0]   rd_word_d;
   logic                rd_go_d;
   logic                s1_valid_q;
   logic [DWIDTH-1:0]   s1_data_q;

   assign busy    = busy_q;
   assign rd_go_d = rd_en && (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clear) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == {AWIDTH{1'b1}}) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Array has no reset; the clear engine owns the write port while busy.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

`ifdef READ_BYPASS_EN
   always_comb begin
      rd_word_d = mem_q[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
               rd_word_d[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end
`else
   assign rd_word_d = mem_q[rd_addr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_go_d;
         if (rd_go_d) begin
            s1_data_q <= rd_word_d;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              s2_valid_q;
         logic [DWIDTH-1:0] s2_data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s1_valid_q;
               if (s1_valid_q) begin
                  s2_data_q <= s1_data_q;
               end
            end
         end

         assign rd_valid = s2_valid_q;
         assign rd_data  = s2_data_q;
      end else begin : g_no_out_reg
         assign rd_valid = s1_valid_q;
         assign rd_data  = s1_data_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dual_port_byte_memory.sv
`default_nettype none
// Bench for dual_port_byte_memory: OUT_REG=0 and OUT_REG=1 instances share
// stimulus and are compared each cycle against a word-level reference model.
module tb_dual_port_byte_memory;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] wr_be = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          busy0, busy1, rd_valid0, rd_valid1;
   logic [DW-1:0] rd_data0, rd_data1;

   always #5 clk = ~clk;

   dual_port_byte_memory #(.AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
   );

   dual_port_byte_memory #(.AWIDTH(AW), .DWIDTH(DW), .OUT_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: word array, remaining clear cycles, expected outputs.
   logic [DW-1:0] mm [DEPTH];
   int            busy_cnt;
   bit            acc_prev;
   logic [DW-1:0] dat_prev;
   bit            ev0, ev1;
   logic [DW-1:0] ed0, ed1;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy_cnt = DEPTH;
      acc_prev = 1'b0;
      dat_prev = '0;
      ev0 = 1'b0; ev1 = 1'b0;
      ed0 = '0;   ed1 = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".busy0"},  {31'd0, busy0},     {31'd0, busy_cnt > 0});
      check({tag, ".busy1"},  {31'd0, busy1},     {31'd0, busy_cnt > 0});
      check({tag, ".valid0"}, {31'd0, rd_valid0}, {31'd0, ev0});
      check({tag, ".data0"},  rd_data0, ed0);
      check({tag, ".valid1"}, {31'd0, rd_valid1}, {31'd0, ev1});
      check({tag, ".data1"},  rd_data1, ed1);
   endtask

   task automatic step(input string tag, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [NB-1:0] be,
                       input bit re, input logic [AW-1:0] ra, input bit clr);
      bit            acc;
      logic [DW-1:0] rv;
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra; clear = clr;
      @(posedge clk);
      acc = 1'b0;
      rv  = '0;
      if (busy_cnt == 0) begin
         if (re) begin
            acc = 1'b1;
            rv  = mm[ra];
`ifdef READ_BYPASS_EN
            if (we && wa == ra)
               for (int b = 0; b < NB; b++) if (be[b]) rv[8*b +: 8] = wd[8*b +: 8];
`endif
         end
         if (we)
            for (int b = 0; b < NB; b++) if (be[b]) mm[wa][8*b +: 8] = wd[8*b +: 8];
         if (clr) begin
            busy_cnt = DEPTH;
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
         end
      end else begin
         busy_cnt--;
      end
      ev1 = acc_prev;
      if (acc_prev) ed1 = dat_prev;
      acc_prev = acc;
      if (acc) dat_prev = rv;
      ev0 = acc;
      if (acc) ed0 = rv;
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, '0, '0, '0, 0, '0, 0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      step("wr", 1, a, d, be, 0, '0, 0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      step("rd", 0, '0, '0, '0, 1, a, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst.valid0", {31'd0, rd_valid0}, 32'd0);
      check("rst.valid1", {31'd0, rd_valid1}, 32'd0);
      check("rst.data0",  rd_data0, 32'd0);
      check("rst.data1",  rd_data1, 32'd0);
      check("rst.busy0",  {31'd0, busy0}, 32'd1);
      model_reset();
      wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      apply_reset();

      // Automatic clear after reset, then every address reads zero.
      idle("init_clear", DEPTH);
      for (int a = 0; a < DEPTH; a++) rd(a[AW-1:0]);
      idle("flush", 2);

      // Partial byte-enable overwrite.
      wr(5'd3, 32'hAABBCCDD, 4'b1111);
      wr(5'd3, 32'h11223344, 4'b0101);
      rd(5'd3);
      check("be_merge", rd_data0, 32'hAA22CC44);
      idle("flush", 2);

      // Back-to-back reads, pipelined latency on the OUT_REG=1 instance.
      for (int a = 0; a < 4; a++) wr(a[AW-1:0], 32'h10 + a, 4'hF);
      for (int a = 0; a < 4; a++) rd(a[AW-1:0]);
      check("b2b_last1", rd_data1, 32'h12);
      idle("flush", 2);
      check("b2b_final1", rd_data1, 32'h13);

      // Same-address read/write collision.
      wr(5'd7, 32'h5, 4'hF);
      step("collide", 1, 5'd7, 32'hFFFFFFFF, 4'b0011, 1, 5'd7, 0);
`ifdef READ_BYPASS_EN
      check("collide_val", rd_data0, 32'h0000FFFF);
`else
      check("collide_val", rd_data0, 32'h00000005);
`endif
      rd(5'd7);
      check("collide_after", rd_data0, 32'h0000FFFF);
      idle("flush", 2);

      // Random traffic with narrow addresses to force collisions.
      for (int i = 0; i < 400; i++) begin
         step("rand", $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
      end
      idle("flush", DEPTH + 2);

      // Requested clear with traffic during busy, then full readback.
      for (int a = 0; a < DEPTH; a++) wr(a[AW-1:0], $urandom | 32'h1, 4'hF);
      rd(5'd9);
      step("clr_go", 0, '0, '0, '0, 1, 5'd4, 1);
      for (int i = 0; i < DEPTH; i++)
         step("busy_io", 1, 5'($urandom), $urandom, 4'hF, 1, 5'($urandom),
              $urandom_range(0, 3) == 0);
      check("clear_done", {31'd0, busy0}, 32'd0);
      for (int a = 0; a < DEPTH; a++) rd(a[AW-1:0]);
      idle("flush", 2);

      // Asynchronous reset in the middle of a clear.
      wr(5'd2, 32'hCAFE0001, 4'hF);
      rd(5'd2);
      step("clr_go2", 0, '0, '0, '0, 0, '0, 1);
      idle("clr_mid", 10);
      @(negedge clk);
      #2;
      apply_reset();
      idle("re_clear", DEPTH - 1);
      check("re_clear_busy", {31'd0, busy0}, 32'd1);
      idle("re_clear", 1);
      for (int a = 0; a < 8; a++) rd(a[AW-1:0]);
      idle("flush", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
